reg_file_mp: RTL and testbench

//  Parametrised multi-port register file for the CPU datapath (ID-stage reads, WB-stage writes).
//  - NRD combinational read ports and two write ports (A = ALU writeback, B = load writeback).
//  - Optional write-to-read bypass and hardwired-zero register.
//  - Per-register busy scoreboard for load-use hazard detection.

---
 rtl/reg_file_mp_pkg.sv | 7 +
 rtl/reg_file_mp_rf_scoreboard.sv | 36 +++
 rtl/reg_file_mp.sv | 86 ++++++++
 tb/tb_reg_file_mp.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared register-file defaults, also used by the decoder and hazard unit.
package reg_file_mp_pkg;
   localparam int RF_DW      = 32;
   localparam int RF_AW      = 5;
   localparam int RF_SP_IDX  = 29;
   localparam int RF_SP_INIT = 128;
endpackage

// File: rtl/reg_file_mp_rf_scoreboard.sv
// Per-register busy bits for load-use hazard detection; a write clears, a load issue sets.
module rf_scoreboard #(
   parameter int AW       = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_wa_en,
   input  logic [AW-1:0]     i_wa_addr,
   input  logic              i_wb_en,
   input  logic [AW-1:0]     i_wb_addr,
   input  logic              i_sb_set,
   input  logic [AW-1:0]     i_sb_addr,
   output logic [2**AW-1:0]  o_busy
);
   localparam int DEPTH = 2**AW;

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_nxt;

   // Clears are applied before the set so a newer outstanding load wins.
   always_comb begin
      w_busy_nxt = r_busy;
      if (i_wa_en) w_busy_nxt[i_wa_addr] = 1'b0;
      if (i_wb_en) w_busy_nxt[i_wb_addr] = 1'b0;
      if (i_sb_set) w_busy_nxt[i_sb_addr] = 1'b1;
      if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_busy <= '0;
      else       r_busy <= w_busy_nxt;
   end

   assign o_busy = r_busy;
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NRD combinational reads, ALU (A) and load (B) write ports,
// optional write-to-read bypass, hardwired zero register and busy scoreboard.
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int DW       = RF_DW,
   parameter int AW       = RF_AW,
   parameter int NRD      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   parameter int SP_IDX   = RF_SP_IDX,
   parameter int SP_INIT  = RF_SP_INIT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NRD*AW-1:0] rd_addr_i,
   output logic [NRD*DW-1:0] rd_data_o,
   output logic [NRD-1:0]    busy_o,
   input  logic              wa_en_i,
   input  logic [AW-1:0]     wa_addr_i,
   input  logic [DW-1:0]     wa_data_i,
   input  logic              wb_en_i,
   input  logic [AW-1:0]     wb_addr_i,
   input  logic [DW-1:0]     wb_data_i,
   input  logic              sb_set_i,
   input  logic [AW-1:0]     sb_addr_i
);
   localparam int DEPTH = 2**AW;

   if (NRD < 1 || NRD > 4) begin : g_bad_nrd
      $error("reg_file_mp: NRD must be in 1..4");
   end

   logic [DW-1:0]    r_mem [DEPTH];
   logic [DEPTH-1:0] w_busy;
   logic             w_wa_ok;
   logic             w_wb_ok;

   assign w_wa_ok = wa_en_i && !(ZERO_REG != 0 && wa_addr_i == '0);
   assign w_wb_ok = wb_en_i && !(ZERO_REG != 0 && wb_addr_i == '0);

   // Port B is written last so it wins on an address collision.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= (i == SP_IDX) ? DW'(SP_INIT) : '0;
      end else begin
         if (w_wa_ok) r_mem[wa_addr_i] <= wa_data_i;
         if (w_wb_ok) r_mem[wb_addr_i] <= wb_data_i;
      end
   end

   rf_scoreboard #(
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .i_wa_en   (wa_en_i),
      .i_wa_addr (wa_addr_i),
      .i_wb_en   (wb_en_i),
      .i_wb_addr (wb_addr_i),
      .i_sb_set  (sb_set_i),
      .i_sb_addr (sb_addr_i),
      .o_busy    (w_busy)
   );

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] w_ra;
      logic          w_zero;
      logic          w_hit_a;
      logic          w_hit_b;

      assign w_ra    = rd_addr_i[k*AW +: AW];
      assign w_zero  = (ZERO_REG != 0) && (w_ra == '0);
      assign w_hit_a = (BYPASS != 0) && wa_en_i && (wa_addr_i == w_ra);
      assign w_hit_b = (BYPASS != 0) && wb_en_i && (wb_addr_i == w_ra);

      assign rd_data_o[k*DW +: DW] = w_zero  ? '0        :
                                     w_hit_b ? wb_data_i :
                                     w_hit_a ? wa_data_i :
                                               r_mem[w_ra];
      // A write arriving this cycle satisfies the hazard when bypass is on.
      assign busy_o[k] = w_busy[w_ra] && !(w_hit_a || w_hit_b);
   end
endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: bypassing and non-bypassing instances share stimulus.
module tb_reg_file_mp;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [9:0]  rd_addr_i = '0;
   logic [63:0] rd_data_o, rd_data_nb;
   logic [1:0]  busy_o, busy_nb;
   logic        wa_en_i = 1'b0, wb_en_i = 1'b0, sb_set_i = 1'b0;
   logic [4:0]  wa_addr_i = '0, wb_addr_i = '0, sb_addr_i = '0;
   logic [31:0] wa_data_i = '0, wb_data_i = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   reg_file_mp #(.BYPASS(1), .ZERO_REG(1)) u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
      .busy_o(busy_o), .wa_en_i(wa_en_i), .wa_addr_i(wa_addr_i), .wa_data_i(wa_data_i),
      .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .sb_set_i(sb_set_i), .sb_addr_i(sb_addr_i));

   reg_file_mp #(.BYPASS(0), .ZERO_REG(1)) u_nb (
      .clk_i(clk_i), .rst_i(rst_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_nb),
      .busy_o(busy_nb), .wa_en_i(wa_en_i), .wa_addr_i(wa_addr_i), .wa_data_i(wa_data_i),
      .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .sb_set_i(sb_set_i), .sb_addr_i(sb_addr_i));

   typedef struct {
      logic [4:0]  ra0, ra1;
      logic        wa_en; logic [4:0] wa_addr; logic [31:0] wa_data;
      logic        wb_en; logic [4:0] wb_addr; logic [31:0] wb_data;
      logic        sb_set; logic [4:0] sb_addr;
      logic [31:0] e0, e1; logic [1:0] eb;
      logic [31:0] n0; logic nb0;
   } vec_t;

   typedef struct {
      logic [31:0] e0, e1; logic [1:0] eb; logic [31:0] n0; logic nb0;
   } exp_t;

   exp_t exp_q[$];
   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] ra0, ra1,
                               input logic wae, input logic [4:0] waa, input logic [31:0] wad,
                               input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
                               input logic sbs, input logic [4:0] sba,
                               input logic [31:0] e0, e1, input logic [1:0] eb,
                               input logic [31:0] n0, input logic nb0);
      vec_t v;
      v.ra0 = ra0; v.ra1 = ra1;
      v.wa_en = wae; v.wa_addr = waa; v.wa_data = wad;
      v.wb_en = wbe; v.wb_addr = wba; v.wb_data = wbd;
      v.sb_set = sbs; v.sb_addr = sba;
      v.e0 = e0; v.e1 = e1; v.eb = eb; v.n0 = n0; v.nb0 = nb0;
      return v;
   endfunction

   // Drive one cycle's inputs, queue the expectation, then check the combinational response.
   task automatic apply(input string name, input vec_t v);
      exp_t e, g;
      @(negedge clk_i);
      rd_addr_i = {v.ra1, v.ra0};
      wa_en_i = v.wa_en; wa_addr_i = v.wa_addr; wa_data_i = v.wa_data;
      wb_en_i = v.wb_en; wb_addr_i = v.wb_addr; wb_data_i = v.wb_data;
      sb_set_i = v.sb_set; sb_addr_i = v.sb_addr;
      e.e0 = v.e0; e.e1 = v.e1; e.eb = v.eb; e.n0 = v.n0; e.nb0 = v.nb0;
      exp_q.push_back(e);
      #2;
      g = exp_q.pop_front();
      chk({name, ".rd0"},  rd_data_o[31:0],  g.e0);
      chk({name, ".rd1"},  rd_data_o[63:32], g.e1);
      chk({name, ".busy"}, 32'(busy_o),      32'(g.eb));
      chk({name, ".nb_rd0"},   rd_data_nb[31:0], g.n0);
      chk({name, ".nb_busy0"}, 32'(busy_nb[0]),  32'(g.nb0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      //     ra0 ra1 waE waA waD           wbE wbA wbD           sbS sbA e0            e1            eb     n0            nb0
      tbl[0]  = mk(5, 29, 1, 5,  32'hDEADBEEF, 0, 0, 32'h0,        0, 0,  32'hDEADBEEF, 32'd128,      2'b00, 32'h0,        0);
      tbl[1]  = mk(5, 7,  1, 7,  32'h1111,     1, 7, 32'h2222,     0, 0,  32'hDEADBEEF, 32'h2222,     2'b00, 32'hDEADBEEF, 0);
      tbl[2]  = mk(7, 0,  1, 0,  32'hFFFFFFFF, 0, 0, 32'h0,        1, 0,  32'h2222,     32'h0,        2'b00, 32'h2222,     0);
      tbl[3]  = mk(0, 7,  0, 0,  32'h0,        1, 0, 32'hFFFFFFFF, 1, 9,  32'h0,        32'h2222,     2'b00, 32'h0,        0);
      tbl[4]  = mk(9, 0,  0, 0,  32'h0,        0, 0, 32'h0,        0, 0,  32'h0,        32'h0,        2'b01, 32'h0,        1);
      tbl[5]  = mk(9, 5,  0, 0,  32'h0,        1, 9, 32'hCAFEF00D, 0, 0,  32'hCAFEF00D, 32'hDEADBEEF, 2'b00, 32'h0,        1);
      tbl[6]  = mk(9, 9,  0, 0,  32'h0,        0, 0, 32'h0,        0, 0,  32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 32'hCAFEF00D, 0);
      tbl[7]  = mk(3, 3,  0, 0,  32'h0,        1, 3, 32'h12345678, 1, 3,  32'h12345678, 32'h12345678, 2'b00, 32'h0,        0);
      tbl[8]  = mk(3, 9,  0, 0,  32'h0,        0, 0, 32'h0,        0, 0,  32'h12345678, 32'hCAFEF00D, 2'b01, 32'h12345678, 1);
      tbl[9]  = mk(3, 12, 1, 3,  32'hA5A5A5A5, 0, 0, 32'h0,        1, 12, 32'hA5A5A5A5, 32'h0,        2'b00, 32'h12345678, 1);
      tbl[10] = mk(3, 12, 1, 12, 32'h77,       0, 0, 32'h0,        1, 12, 32'hA5A5A5A5, 32'h77,       2'b00, 32'hA5A5A5A5, 0);
      tbl[11] = mk(12, 3, 0, 0,  32'h0,        0, 0, 32'h0,        0, 0,  32'h77,       32'hA5A5A5A5, 2'b01, 32'h77,       1);

      // Asynchronous reset mid-cycle, with a write presented that must be dropped.
      @(negedge clk_i);
      rd_addr_i = {5'd1, 5'd29};
      wa_en_i = 1'b1; wa_addr_i = 5'd4; wa_data_i = 32'h55;
      sb_set_i = 1'b1; sb_addr_i = 5'd6;
      #1 rst_i = 1'b1;
      #1;
      chk("rst.rd29", rd_data_o[31:0],  32'd128);
      chk("rst.rd1",  rd_data_o[63:32], 32'h0);
      chk("rst.busy", 32'(busy_o), 32'h0);
      chk("rst.nb_rd29", rd_data_nb[31:0], 32'd128);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      wa_en_i = 1'b0; sb_set_i = 1'b0;
      rd_addr_i = {5'd6, 5'd4};
      #2;
      chk("rst.drop_wr4", rd_data_o[31:0], 32'h0);
      chk("rst.drop_set6", 32'(busy_o), 32'h0);

      for (int i = 0; i < 12; i++) apply($sformatf("vec%0d", i), tbl[i]);

      // Reset pulse clears stored data and busy bits; SP register returns to its init value.
      @(negedge clk_i);
      wa_en_i = 1'b0; wb_en_i = 1'b0; sb_set_i = 1'b0;
      rd_addr_i = {5'd12, 5'd3};
      rst_i = 1'b1;
      #1;
      chk("pulse.rd3",  rd_data_o[31:0],  32'h0);
      chk("pulse.rd12", rd_data_o[63:32], 32'h0);
      chk("pulse.busy", 32'(busy_o), 32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;
      rd_addr_i = {5'd29, 5'd9};
      #2;
      chk("pulse.rd9",    rd_data_o[31:0],  32'h0);
      chk("pulse.rd29",   rd_data_o[63:32], 32'd128);
      chk("pulse.nb_rd9", rd_data_nb[31:0], 32'h0);
      chk("pulse.nb_busy", 32'(busy_nb), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
